// File: rtl/tx_slot_serializer_if.sv
// Upstream payload stream into the slot serializer: one word per valid/ready transfer.
interface tx_slot_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/tx_slot_serializer.sv
// Bit-serial slot framer: on each slot flag sends a fixed preamble then WORDS_PER_SLOT
// upstream words MSB first, one bit per rising edge of the divided clock level clk_25m.
module tx_slot_serializer #(
    parameter int                DATA_W         = 8,
    parameter int                WORDS_PER_SLOT = 4,
    parameter int                PRE_W          = 8,
    parameter logic [PRE_W-1:0]  PRE_PATTERN    = PRE_W'(8'hA5)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_25m,
    input  logic                   time_slot_flag,
    tx_slot_serializer_if.slave    up,
    output logic                   tx_bit,
    output logic                   tx_en,
    output logic                   busy,
    output logic                   underrun
);
    localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int BC_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int WC_W  = $clog2(WORDS_PER_SLOT + 1);

    localparam logic [BC_W-1:0] PRE_LAST  = BC_W'(PRE_W - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [WC_W-1:0] WORDS_MAX = WC_W'(WORDS_PER_SLOT);
    localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t            state;
    logic              clk_25m_d;
    logic              tick;
    logic              hold_valid;
    logic              take;
    logic              word_start;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] word_sr;
    logic [PRE_W-1:0]  pre_sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   words_started;

    assign tick       = clk_25m & ~clk_25m_d;
    assign busy       = (state != IDLE);
    assign up.s_ready = (state != IDLE) & ~hold_valid & (words_started < WORDS_MAX);
    assign take       = up.s_valid & up.s_ready;
    assign word_start = (state == DATA) & tick & (bit_cnt == '0) & (words_started < WORDS_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clk_25m_d     <= 1'b0;
            tx_bit        <= 1'b0;
            tx_en         <= 1'b0;
            underrun      <= 1'b0;
            hold_valid    <= 1'b0;
            bit_cnt       <= '0;
            words_started <= '0;
        end else begin
            clk_25m_d <= clk_25m;
            underrun  <= 1'b0;

            // A transfer needs an empty holding register, so it never races the word-start consume.
            if (take)
                hold_valid <= 1'b1;
            else if (word_start && hold_valid)
                hold_valid <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt       <= '0;
                    words_started <= '0;
                    tx_en         <= 1'b0;
                    tx_bit        <= 1'b0;
                    if (time_slot_flag)
                        state <= PRE;
                end
                PRE: begin
                    if (tick) begin
                        tx_bit <= pre_sr[PRE_W-1];
                        tx_en  <= 1'b1;
                        if (bit_cnt == PRE_LAST) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BC_ONE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        // bit_cnt has wrapped after the last bit of the last word: close the frame.
                        if (bit_cnt == '0 && words_started == WORDS_MAX) begin
                            state  <= IDLE;
                            tx_en  <= 1'b0;
                            tx_bit <= 1'b0;
                        end else begin
                            tx_en <= 1'b1;
                            if (bit_cnt == '0) begin
                                words_started <= words_started + WC_ONE;
                                tx_bit        <= hold_valid & hold_reg[DATA_W-1];
                                underrun      <= ~hold_valid;
                            end else begin
                                tx_bit <= word_sr[DATA_W-1];
                            end
                            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BC_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath shift/holding registers carry no reset; hold_valid alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (state == IDLE)
            pre_sr <= PRE_PATTERN;
        else if (state == PRE && tick)
            pre_sr <= pre_sr << 1;

        if (take)
            hold_reg <= up.s_data;

        if (word_start)
            word_sr <= hold_valid ? (hold_reg << 1) : '0;
        else if (state == DATA && tick)
            word_sr <= word_sr << 1;
    end
endmodule

// File: tb/tb_tx_slot_serializer.sv
// Directed bench for tx_slot_serializer: frames are reassembled from tx_bit on each
// divided-clock tick and compared with hand-computed bit patterns.
module tb_tx_slot_serializer;
    localparam int DATA_W = 8;
    localparam int WPS    = 2;
    localparam int PRE_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_25m = 1'b0;
    logic time_slot_flag = 1'b0;
    logic tx_bit, tx_en, busy, underrun;

    tx_slot_serializer_if #(.DATA_W(DATA_W)) sif ();

    tx_slot_serializer #(
        .DATA_W(DATA_W), .WORDS_PER_SLOT(WPS), .PRE_W(PRE_W), .PRE_PATTERN(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .clk_25m(clk_25m), .time_slot_flag(time_slot_flag),
        .up(sif), .tx_bit(tx_bit), .tx_en(tx_en), .busy(busy), .underrun(underrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial forever #5 clk = ~clk;

    // Divided clock level: toggles every 2 clk, can be frozen.
    bit c25_run = 1'b1;
    int c25_ph  = 0;
    initial forever begin
        @(negedge clk);
        if (c25_run) begin
            c25_ph++;
            clk_25m = c25_ph[1];
        end
    end

    // Upstream source: mode 0 idle, 1 present words back to back, 2 random gaps.
    int         src_mode = 0;
    int         gap = 0;
    logic [7:0] src_q[$];
    logic [7:0] acc_q[$];
    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (src_mode == 2 && src_q.size() < 2) src_q.push_back(8'($urandom));
            if (gap > 0) gap--;
            if (src_mode != 0 && src_q.size() > 0 && gap == 0) begin
                sif.s_valid = 1'b1;
                sif.s_data  = src_q[0];
            end else begin
                sif.s_valid = 1'b0;
            end
            #1;
            if (sif.s_valid && sif.s_ready) begin
                acc_q.push_back(src_q.pop_front());
                if (src_mode == 2) gap = $urandom_range(0, 50);
            end
        end
    end

    // Frame capture: one bit per tick while tx_en; frame closes when tx_en drops.
    logic        c25_prev = 1'b0;
    bit          tk;
    int          flen = 0, fund = 0, fcyc = 0;
    logic [63:0] fbits = '0;
    logic [7:0]  fmask = '0;
    logic [63:0] fr_bits[$];
    int          fr_len[$], fr_und[$], fr_cyc[$];
    logic [7:0]  fr_mask[$];
    initial forever begin
        @(posedge clk);
        tk = clk_25m & ~c25_prev;
        c25_prev = rst ? 1'b0 : clk_25m;
        #1;
        if (underrun) begin
            check("und_on_tick", 64'(tk), 64'd1);
            check("und_word_start", 64'((flen - PRE_W) % DATA_W), 64'd0);
            if (flen >= PRE_W) fmask[(flen - PRE_W) / DATA_W] = 1'b1;
            fund++;
        end
        if (tx_en) fcyc++;
        if (tk && tx_en) begin
            fbits = {fbits[62:0], tx_bit};
            flen++;
        end else if (!tx_en && flen > 0) begin
            fr_bits.push_back(fbits); fr_len.push_back(flen);
            fr_und.push_back(fund);   fr_cyc.push_back(fcyc);
            fr_mask.push_back(fmask);
            fbits = '0; flen = 0; fund = 0; fcyc = 0; fmask = '0;
        end
    end

    task automatic pulse_flag();
        @(negedge clk);
        time_slot_flag = 1'b1;
        @(negedge clk);
        time_slot_flag = 1'b0;
    endtask

    task automatic wait_flen(input int n, input int budget);
        int k = 0;
        while (flen < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (flen < n) check("flen_timeout", 64'(flen), 64'(n));
    endtask

    task automatic get_frame(input int budget, output logic [63:0] b, output int len,
                             output int und, output int cyc, output logic [7:0] m);
        int k = 0;
        while (fr_len.size() == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (fr_len.size() == 0) begin
            check("frame_timeout", 64'd0, 64'd1);
            b = '0; len = 0; und = 0; cyc = 0; m = '0;
        end else begin
            b = fr_bits.pop_front(); len = fr_len.pop_front();
            und = fr_und.pop_front(); cyc = fr_cyc.pop_front();
            m = fr_mask.pop_front();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] b;
        logic [7:0]  m;
        logic [7:0]  w;
        int          len, und, cyc, fz, tot_und, zero_words, k;

        repeat (3) @(negedge clk);
        check("rst_tx_en", 64'(tx_en), 64'd0);
        check("rst_tx_bit", 64'(tx_bit), 64'd0);
        check("rst_s_ready", 64'(sif.s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);

        time_slot_flag = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        time_slot_flag = 1'b0;
        @(negedge clk);
        check("flag_during_rst", 64'(busy), 64'd0);

        // Full frame with both words ready
        src_q = '{8'h3C, 8'hF0};
        src_mode = 1;
        pulse_flag();
        check("busy_after_flag", 64'(busy), 64'd1);
        check("ready_in_pre", 64'(sif.s_ready), 64'd1);
        get_frame(400, b, len, und, cyc, m);
        check("t1_bits", b, 64'hA53CF0);
        check("t1_len", 64'(len), 64'd24);
        check("t1_underruns", 64'(und), 64'd0);
        check("t1_en_cycles", 64'(cyc), 64'd96);
        check("t1_busy_end", 64'(busy), 64'd0);

        // Word 1 missing -> zero word plus one underrun
        src_q = '{8'h3C};
        pulse_flag();
        get_frame(400, b, len, und, cyc, m);
        check("t2_bits", b, 64'hA53C00);
        check("t2_len", 64'(len), 64'd24);
        check("t2_underruns", 64'(und), 64'd1);
        check("t2_und_word", 64'(m), 64'h2);

        // Flag while busy is ignored
        src_q = '{8'h11, 8'h22};
        pulse_flag();
        wait_flen(10, 200);
        pulse_flag();
        get_frame(400, b, len, und, cyc, m);
        check("t3_bits", b, 64'hA51122);
        check("t3_len", 64'(len), 64'd24);
        repeat (150) @(negedge clk);
        check("t3_no_restart_busy", 64'(busy), 64'd0);
        check("t3_no_extra_frame", 64'(fr_len.size() + flen), 64'd0);
        src_q = '{8'h5A, 8'hC3};
        pulse_flag();
        get_frame(400, b, len, und, cyc, m);
        check("t3_fresh_bits", b, 64'hA55AC3);

        // Reset mid-frame, word 1 already prefetched
        src_q = '{8'h77, 8'h88};
        pulse_flag();
        wait_flen(12, 200);
        rst = 1'b1;
        #1;
        check("t4_tx_en", 64'(tx_en), 64'd0);
        check("t4_tx_bit", 64'(tx_bit), 64'd0);
        check("t4_s_ready", 64'(sif.s_ready), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        get_frame(50, b, len, und, cyc, m);
        check("t4_partial_len", 64'(len), 64'd12);
        check("t4_partial_bits", b, 64'hA57);
        acc_q.delete();
        src_q = '{8'h99, 8'h66};
        pulse_flag();
        get_frame(400, b, len, und, cyc, m);
        check("t4_after_rst_bits", b, 64'hA59966);

        // clk_25m frozen high mid-frame
        src_q = '{8'hE7, 8'h18};
        pulse_flag();
        wait_flen(10, 200);
        k = 0;
        do begin
            @(negedge clk);
            #3;
            k++;
        end while (!clk_25m && k < 10);
        c25_run = 1'b0;
        repeat (2) @(negedge clk);
        fz = flen;
        repeat (38) @(negedge clk);
        check("t5_frozen_bits", 64'(flen), 64'(fz));
        check("t5_frozen_tx_en", 64'(tx_en), 64'd1);
        #3 c25_run = 1'b1;
        get_frame(400, b, len, und, cyc, m);
        check("t5_bits", b, 64'hA5E718);
        check("t5_len", 64'(len), 64'd24);

        // Random source gaps over 50 slots
        acc_q.delete();
        src_q.delete();
        src_mode = 2;
        tot_und = 0;
        zero_words = 0;
        for (int s = 0; s < 50; s++) begin
            pulse_flag();
            get_frame(400, b, len, und, cyc, m);
            check("rnd_len", 64'(len), 64'd24);
            check("rnd_pre", 64'(b[23:16]), 64'hA5);
            for (int i = 0; i < WPS; i++) begin
                w = 8'(b >> ((WPS - 1 - i) * DATA_W));
                if (m[i]) begin
                    check("rnd_zero_word", 64'(w), 64'd0);
                    zero_words++;
                end else if (acc_q.size() == 0) begin
                    check("rnd_word_unexpected", 64'(w), 64'd0);
                end else begin
                    check("rnd_word", 64'(w), 64'(acc_q.pop_front()));
                end
            end
            tot_und += und;
        end
        src_mode = 0;
        check("rnd_underrun_count", 64'(tot_und), 64'(zero_words));
        check("rnd_leftover", 64'(acc_q.size() <= 1), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_slot_serializer.md
Name: tx_slot_serializer

Overview:
- Bit-serial TX framer downstream of the 25 MHz divided-clock generator. Runs entirely in the clk domain.
- Treats the divided clock level clk_25m as a bit-rate reference: one serial bit per rising edge of clk_25m, i.e. one bit every 4 clk cycles.
- On each time_slot_flag it emits one slot frame: a fixed preamble followed by WORDS_PER_SLOT words pulled from an upstream valid/ready source, MSB first.

Parameters:
DATA_W, 8, width of each payload word
WORDS_PER_SLOT, 4, payload words per slot frame (>=1)
PRE_W, 8, preamble length in bits (>=1)
PRE_PATTERN, 8'hA5, preamble bits; sent MSB first (PRE_W bits wide)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
clk_25m  in  1  divided clock level from the 25 MHz generator; sampled in the clk domain
time_slot_flag  in  1  one-clk pulse marking slot start
s_data  in  DATA_W  payload word
s_valid  in  1  s_data valid
s_ready  out  1  block can accept a word this cycle
tx_bit  out  1  serial data, registered
tx_en  out  1  high while frame bits are on tx_bit, registered
busy  out  1  state != IDLE
underrun  out  1  one-clk pulse when a word slot had no data

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state updates occur on clk.
- clk_25m_d is a register of clk_25m. tick = clk_25m & ~clk_25m_d (combinational). tick fires once per 4 clk while clk_25m toggles.
- If clk_25m is stuck, no tick occurs and all bit state holds.
- Reset values: state=IDLE, tx_bit=0, tx_en=0, s_ready=0, busy=0, underrun=0, hold_valid=0, all counters=0, clk_25m_d=0.
- States: IDLE, PRE, DATA.
- IDLE:
  - time_slot_flag=1 -> PRE next cycle.
  - Preamble shift register loads PRE_PATTERN; bit_cnt=0; words_started=0.
  - tx_en=0, tx_bit=0.
- PRE:
  - On each tick: tx_bit <= MSB of the preamble shift register, tx_en <= 1, shift left, bit_cnt++.
  - After the PRE_W-th preamble tick: state goes to DATA, bit_cnt=0.
- Upstream handshake:
  - s_ready = (state is PRE or DATA) & ~hold_valid & (words_started < WORDS_PER_SLOT). s_ready is a combinational decode of registered state.
  - Transfer occurs when s_valid & s_ready: s_data is captured into hold_reg and hold_valid is set.
  - Prefetch of word 0 during PRE is allowed.
- DATA, at the tick that starts a word (bit_cnt==0):
  - If hold_valid=1: the word shift register loads hold_reg, hold_valid clears, and its MSB drives tx_bit at this tick.
  - If hold_valid=0: the word shift register loads all-zeros, underrun pulses for 1 clk, and the zero word is transmitted in full.
  - In both cases words_started increments.
- DATA, other ticks: shift out the next bit with tx_en=1; bit_cnt wraps at DATA_W.
- Frame end:
  - The last bit is bit DATA_W-1 of word WORDS_PER_SLOT-1.
  - At the next tick: tx_en <= 0, tx_bit <= 0, state goes to IDLE.
  - A frame therefore occupies exactly PRE_W + WORDS_PER_SLOT*DATA_W ticks of tx_en=1.
- Latency: time_slot_flag in cycle T -> first preamble bit appears on the first tick at cycle >= T+1, visible the cycle after that tick.
- time_slot_flag while busy=1 is ignored. This includes the IDLE-return tick cycle.
- time_slot_flag in the same cycle as reset deassertion: ignored only if rst is still high.
- A handshake in the same cycle as a word-start tick with hold_valid=0 does not rescue that word. The word is sent as zeros, and the captured data becomes the next word.
- Reset mid-frame:
  - All outputs return to reset values immediately.
  - The partial frame is dropped, and hold_reg contents are discarded.
- Counter widths: bit_cnt is clog2(max(PRE_W,DATA_W)) bits; words_started is clog2(WORDS_PER_SLOT+1) bits. No wrap within a frame.

Test Plan:
- Defaults except WORDS_PER_SLOT=2. s_valid held high with 8'h3C then 8'hF0, then one flag pulse -> tx_bit = 10100101 00111100 11110000. tx_en high for 24 ticks (96 clk); underrun never asserts; busy drops after the frame.
- As above, but s_valid is low when word 1 starts -> word 1 transmitted as 00000000. underrun pulses exactly once, 1 clk wide, aligned with that start tick.
- Second time_slot_flag 10 ticks into a frame -> no effect on the bit stream; after IDLE, a new flag starts a fresh A5 preamble.
- rst asserted at tick 12 of a frame -> tx_en=0, tx_bit=0, s_ready=0 immediately. The next flag yields a complete correct frame with no stale hold data.
- clk_25m frozen high for 40 clk mid-frame, then resumed -> no bits lost or duplicated; the sequence continues exactly where it paused.
- s_valid toggling randomly, with data checked against a scoreboard over 50 slots -> every accepted word appears once, in order. Each underrun pulse count equals the number of zero words inserted.
